// File: rtl/pipe_ctrl_track.sv
// Pipeline-register tracking bank. Holds the PC and the IF/ID, ID/EX,
// EX/MEM and MEM/WB bookkeeping fields, applies the hazard detector's
// GO/HOLD/FLUSH code to each stage register on every rising edge, and keeps
// saturating stall/flush performance counters.

// One stage register. GO loads the upstream word, FLUSH loads the bubble
// word, and HOLD or the reserved code retains the current contents.
module pipe_stage_reg #(
    parameter int          W       = 40,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   ctrl,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stage update: the reset value doubles as the flush bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            case (ctrl)
                2'b00:   q <= d;
                2'b10:   q <= RST_VAL;
                default: q <= q;
            endcase
        end
    end

endmodule

module pipe_ctrl_track #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h5400_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_next,
    input  logic             pc_enable,
    input  logic [31:0]      if_instr,
    input  logic             if_valid,
    input  logic [4:0]       id_rd,
    input  logic             id_regWr,
    input  logic             id_memRd,
    input  logic             id_memWr,
    input  logic [1:0]       if_id_ctrl,
    input  logic [1:0]       id_ex_ctrl,
    input  logic [1:0]       ex_mem_ctrl,
    input  logic [1:0]       mem_wb_ctrl,
    input  logic             cnt_clr,
    output logic [31:0]      pc,
    output logic [31:0]      id_instr,
    output logic [31:0]      ex_instr,
    output logic [31:0]      mem_instr,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [4:0]       ex_rd,
    output logic [4:0]       mem_rd,
    output logic [4:0]       wb_rd,
    output logic             ex_memRd,
    output logic             ex_memWr,
    output logic             mem_memRd,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int NUM_STAGES = 4;
    localparam logic [1:0] CTRL_FLUSH = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
    } stage_t;

    localparam int SW = $bits(stage_t);
    localparam stage_t STAGE_NOP = '{valid: 1'b0, instr: NOP_INSTR, rd: 5'd0,
                                     mem_rd: 1'b0, mem_wr: 1'b0};

    // Index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB.
    stage_t [NUM_STAGES-1:0]   stg_d;
    stage_t [NUM_STAGES-1:0]   stg_q;
    logic   [NUM_STAGES-1:0][1:0] stg_ctrl;
    logic                      flush_any;

    assign stg_ctrl = {mem_wb_ctrl, ex_mem_ctrl, id_ex_ctrl, if_id_ctrl};

    // Upstream words. IF/ID carries no rd/mem flags yet; the decoded fields
    // join at the ID->EX load, with non-writers forced to R0 so they never
    // match a hazard compare. Invalid entries travel unchanged.
    always_comb begin
        stg_d[0] = '{valid: if_valid, instr: if_instr, rd: 5'd0,
                     mem_rd: 1'b0, mem_wr: 1'b0};
        stg_d[1] = '{valid: stg_q[0].valid, instr: stg_q[0].instr,
                     rd: id_regWr ? id_rd : 5'd0,
                     mem_rd: id_memRd, mem_wr: id_memWr};
        stg_d[2] = stg_q[1];
        stg_d[3] = stg_q[2];
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        pipe_stage_reg #(
            .W       (SW),
            .RST_VAL (STAGE_NOP)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .ctrl  (stg_ctrl[g]),
            .d     (stg_d[g]),
            .q     (stg_q[g])
        );
    end

    // PC register: loads only when the hazard detector enables it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         pc <= RESET_PC;
        else if (pc_enable) pc <= pc_next;
    end

    always_comb begin
        flush_any = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++)
            if (stg_ctrl[i] == CTRL_FLUSH) flush_any = 1'b1;
    end

    // Saturating counters; clear wins over increment, even at saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_enable && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_any  && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign id_instr  = stg_q[0].instr;
    assign id_valid  = stg_q[0].valid;
    assign ex_instr  = stg_q[1].instr;
    assign ex_valid  = stg_q[1].valid;
    assign ex_rd     = stg_q[1].rd;
    assign ex_memRd  = stg_q[1].mem_rd;
    assign ex_memWr  = stg_q[1].mem_wr;
    assign mem_instr = stg_q[2].instr;
    assign mem_valid = stg_q[2].valid;
    assign mem_rd    = stg_q[2].rd;
    assign mem_memRd = stg_q[2].mem_rd;
    assign wb_valid  = stg_q[3].valid;
    assign wb_rd     = stg_q[3].rd;

endmodule

// File: tb/tb_pipe_ctrl_track.sv
// Directed bench for pipe_ctrl_track: a stage-level model checked on every
// falling edge, plus hand-computed literal expectations at key points.
module tb_pipe_ctrl_track;

    localparam logic [31:0] NOP = 32'h5400_0000;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pc_next = '0;
    logic          pc_enable = 1'b0;
    logic [31:0]   if_instr = '0;
    logic          if_valid = 1'b0;
    logic [4:0]    id_rd = '0;
    logic          id_regWr = 1'b0, id_memRd = 1'b0, id_memWr = 1'b0;
    logic [1:0]    if_id_ctrl = 2'b00, id_ex_ctrl = 2'b00;
    logic [1:0]    ex_mem_ctrl = 2'b00, mem_wb_ctrl = 2'b00;
    logic          cnt_clr = 1'b0;
    logic [31:0]   pc, id_instr, ex_instr, mem_instr;
    logic          id_valid, ex_valid, mem_valid, wb_valid;
    logic [4:0]    ex_rd, mem_rd, wb_rd;
    logic          ex_memRd, ex_memWr, mem_memRd;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    pipe_ctrl_track #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc_enable(pc_enable),
        .if_instr(if_instr), .if_valid(if_valid), .id_rd(id_rd),
        .id_regWr(id_regWr), .id_memRd(id_memRd), .id_memWr(id_memWr),
        .if_id_ctrl(if_id_ctrl), .id_ex_ctrl(id_ex_ctrl),
        .ex_mem_ctrl(ex_mem_ctrl), .mem_wb_ctrl(mem_wb_ctrl),
        .cnt_clr(cnt_clr), .pc(pc), .id_instr(id_instr), .ex_instr(ex_instr),
        .mem_instr(mem_instr), .id_valid(id_valid), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid), .ex_rd(ex_rd),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_memRd(ex_memRd),
        .ex_memWr(ex_memWr), .mem_memRd(mem_memRd),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
    } st_t;

    localparam st_t BUBBLE = '{v: 1'b0, ins: NOP, rd: 5'd0, mr: 1'b0, mw: 1'b0};

    st_t  m0, m1, m2, m3;
    logic [31:0] mpc;
    int   ms, mf;

    function automatic st_t apply(st_t cur, st_t up, logic [1:0] c);
        if (c == 2'b00) return up;
        if (c == 2'b10) return BUBBLE;
        return cur;
    endfunction

    function automatic bit any_flush(logic [1:0] a, logic [1:0] b,
                                     logic [1:0] c, logic [1:0] d);
        return (a == 2'b10) || (b == 2'b10) || (c == 2'b10) || (d == 2'b10);
    endfunction

    // Model advance on each edge (async reset mirrors the stated reset values).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= BUBBLE; m1 <= BUBBLE; m2 <= BUBBLE; m3 <= BUBBLE;
            mpc <= 32'h0; ms <= 0; mf <= 0;
        end else begin
            m0 <= apply(m0, '{v: if_valid, ins: if_instr, rd: 5'd0, mr: 1'b0, mw: 1'b0},
                        if_id_ctrl);
            m1 <= apply(m1, '{v: m0.v, ins: m0.ins, rd: (id_regWr ? id_rd : 5'd0),
                              mr: id_memRd, mw: id_memWr}, id_ex_ctrl);
            m2 <= apply(m2, m1, ex_mem_ctrl);
            m3 <= apply(m3, m2, mem_wb_ctrl);
            if (pc_enable) mpc <= pc_next;
            if (cnt_clr) begin
                ms <= 0;
                mf <= 0;
            end else begin
                if (!pc_enable) ms <= (ms < CMAX) ? ms + 1 : ms;
                if (any_flush(if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl))
                    mf <= (mf < CMAX) ? mf + 1 : mf;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("pc",        64'(pc),        64'(mpc));
        chk("id_instr",  64'(id_instr),  64'(m0.ins));
        chk("id_valid",  64'(id_valid),  64'(m0.v));
        chk("ex_instr",  64'(ex_instr),  64'(m1.ins));
        chk("ex_valid",  64'(ex_valid),  64'(m1.v));
        chk("ex_rd",     64'(ex_rd),     64'(m1.rd));
        chk("ex_memRd",  64'(ex_memRd),  64'(m1.mr));
        chk("ex_memWr",  64'(ex_memWr),  64'(m1.mw));
        chk("mem_instr", 64'(mem_instr), 64'(m2.ins));
        chk("mem_valid", 64'(mem_valid), 64'(m2.v));
        chk("mem_rd",    64'(mem_rd),    64'(m2.rd));
        chk("mem_memRd", 64'(mem_memRd), 64'(m2.mr));
        chk("wb_valid",  64'(wb_valid),  64'(m3.v));
        chk("wb_rd",     64'(wb_rd),     64'(m3.rd));
        chk("stall_cnt", 64'(stall_cnt), 64'(ms));
        chk("flush_cnt", 64'(flush_cnt), 64'(mf));
    end

    // Advance one edge; return just after the falling-edge compare.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ctrl(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
        if_id_ctrl = a; id_ex_ctrl = b; ex_mem_ctrl = c; mem_wb_ctrl = d;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    64'(pc),        64'h0);
        chk({tag, "_id"},    64'(id_instr),  64'(NOP));
        chk({tag, "_ex"},    64'(ex_instr),  64'(NOP));
        chk({tag, "_mem"},   64'(mem_instr), 64'(NOP));
        chk({tag, "_vld"},   64'({id_valid, ex_valid, mem_valid, wb_valid}), 64'h0);
        chk({tag, "_rd"},    64'({ex_rd, mem_rd, wb_rd}), 64'h0);
        chk({tag, "_flags"}, 64'({ex_memRd, ex_memWr, mem_memRd}), 64'h0);
        chk({tag, "_cnt"},   64'({stall_cnt, flush_cnt}), 64'h0);
    endtask

    initial begin
        tick(); tick();
        chk_reset_vals("rst");

        // All-GO fill with A, B, C.
        rst_n = 1'b1;
        pc_enable = 1'b1; if_valid = 1'b1; ctrl(2'b00, 2'b00, 2'b00, 2'b00);
        if_instr = 32'hA000_0001; pc_next = 32'h4; tick();
        if_instr = 32'hB000_0002; pc_next = 32'h8; tick();
        if_instr = 32'hC000_0003; pc_next = 32'hC; tick();
        chk("fill_mem", 64'(mem_instr), 64'hA000_0001);
        chk("fill_ex",  64'(ex_instr),  64'hB000_0002);
        chk("fill_id",  64'(id_instr),  64'hC000_0003);
        chk("fill_vld", 64'({id_valid, ex_valid, mem_valid}), 64'h7);

        // ID->EX load of C with rd=5 (a load), D enters IF/ID.
        if_instr = 32'hD000_0004; pc_next = 32'h10;
        id_rd = 5'd5; id_regWr = 1'b1; id_memRd = 1'b1; tick();
        chk("lu_ex_rd", 64'(ex_rd), 64'd5);

        // Load-use stall cycle.
        if_instr = 32'hE000_0005; pc_next = 32'h14; pc_enable = 1'b0;
        id_rd = 5'd9; id_memRd = 1'b0;
        ctrl(2'b01, 2'b10, 2'b00, 2'b00); tick();
        chk("st_id",     64'(id_instr),  64'hD000_0004);
        chk("st_ex",     64'(ex_instr),  64'(NOP));
        chk("st_ex_rd",  64'(ex_rd),     64'd0);
        chk("st_ex_vld", 64'(ex_valid),  64'd0);
        chk("st_mem_rd", 64'(mem_rd),    64'd5);
        chk("st_mem_mr", 64'(mem_memRd), 64'd1);
        chk("st_pc",     64'(pc),        64'h10);
        chk("st_stall",  64'(stall_cnt), 64'd1);
        chk("st_flush",  64'(flush_cnt), 64'd1);

        // Non-writing instruction carries R0 but stays valid.
        ctrl(2'b00, 2'b00, 2'b00, 2'b00); pc_enable = 1'b1;
        id_regWr = 1'b0; id_rd = 5'd7; pc_next = 32'h18; tick();
        chk("nw_ex_rd",  64'(ex_rd),    64'd0);
        chk("nw_ex_vld", 64'(ex_valid), 64'd1);
        chk("nw_ex",     64'(ex_instr), 64'hD000_0004);

        if_instr = 32'hF000_0006; tick();
        chk("pre_rsv_mem", 64'(mem_instr), 64'hD000_0004);

        // Reserved code on EX/MEM behaves as HOLD for 3 cycles.
        ex_mem_ctrl = 2'b11;
        for (int i = 0; i < 3; i++) begin
            if_instr = 32'h1000_0000 + 32'(i); tick();
        end
        chk("rsv_mem",   64'(mem_instr), 64'hD000_0004);
        chk("rsv_vld",   64'(mem_valid), 64'd1);
        chk("rsv_flush", 64'(flush_cnt), 64'd1);
        chk("rsv_stall", 64'(stall_cnt), 64'd1);
        ex_mem_ctrl = 2'b00;

        // Stall counter saturation, then clear with a concurrent stall.
        pc_enable = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 64'(stall_cnt), 64'd15);
        chk("sat_pc",    64'(pc),        64'h18);
        cnt_clr = 1'b1; tick();
        chk("clr_stall", 64'(stall_cnt), 64'd0);
        chk("clr_flush", 64'(flush_cnt), 64'd0);
        cnt_clr = 1'b0;

        // Reset asserted between edges in the middle of a stall.
        ctrl(2'b01, 2'b10, 2'b00, 2'b00); tick();
        chk("ms_stall", 64'(stall_cnt), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        tick();
        rst_n = 1'b1;
        ctrl(2'b00, 2'b00, 2'b00, 2'b00); pc_enable = 1'b1;
        if_instr = 32'h2BAD_CAFE; pc_next = 32'h40; tick();
        chk("post_id",  64'(id_instr), 64'h2BAD_CAFE);
        chk("post_vld", 64'(id_valid), 64'd1);
        chk("post_pc",  64'(pc),       64'h40);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
